alu_rr_scheduler: RTL and testbench
===================================

// Module: alu_rr_scheduler
// PURPOSE
//  Round-robin scheduler sharing one combinational 8-bit ALU (add/sub/shl/shr/and/or/xor/not)
//  between NREQ requesters. Accepts one operation per grant, drives the ALU from registered
//  operands, captures result and carry, and returns them to the granted requester via a
//  valid/ready response. Sits between client engines and the single ALU instance.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  IDW    2   requester-ID width, $clog2(NREQ)
//  CNTW   16  width of the completed-operation counter
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst        in   1          synchronous reset, active-high
//  req_valid  in   NREQ       requester i has an operation pending
//  req_ready  out  NREQ       one-hot accept; handshake = req_valid[i] & req_ready[i]
//  req_a      in   NREQ*8     operand a, requester i at [8i+7:8i]
//  req_b      in   NREQ*8     operand b, same packing
//  req_sel    in   NREQ*3     opcode, requester i at [3i+2:3i]
//  alu_a      out  8          to ALU operand a (registered)
//  alu_b      out  8          to ALU operand b (registered)
//  alu_sel    out  3          to ALU opcode (registered)
//  alu_res    in   8          from ALU result
//  alu_c      in   1          from ALU carry/borrow
//  rsp_valid  out  1          result available
//  rsp_ready  in   1          consumer accepts result
//  rsp_id     out  IDW        requester that owns the result
//  rsp_res    out  8          captured result
//  rsp_c      out  1          captured carry, masked (see below)
//  busy       out  1          high in ISSUE or RESP
//  op_count   out  CNTW       number of completed response handshakes
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, req_ready=0, alu_a/b/sel=0, rsp_valid=0, rsp_id=0, rsp_res=0,
//   rsp_c=0, busy=0, op_count=0. Reset mid-operation drops the in-flight op; no response issued.
//  FSM: IDLE -> ISSUE -> RESP -> IDLE.
//  IDLE: grant = first i with req_valid[i], searching ptr, ptr+1, ... mod NREQ.
//   req_ready is combinational: only bit grant high, and only in IDLE. No valid -> req_ready=0.
//   On a handshake: latch a/b/sel of the granted requester into alu_a/b/sel, latch id,
//   ptr <= grant+1 mod NREQ, go to ISSUE.
//  ISSUE (1 cycle): the ALU settles on the registered inputs; at the clock edge capture
//   rsp_res<=alu_res, rsp_c<=(alu_sel[2] ? 0 : alu_c), rsp_id<=id; go to RESP.
//   rsp_c is forced to 0 for logic ops (sel 100..111) because the ALU leaves carry undefined there.
//  RESP: rsp_valid=1. rsp_res/c/id are held stable until rsp_ready=1. On the handshake:
//   rsp_valid<=0, op_count<=op_count+1 (wraps at 2^CNTW-1 -> 0), go to IDLE.
//  Latency: request handshake at cycle T -> rsp_valid first high at T+2. Best-case throughput
//   is 1 op per 3 cycles. The next grant is decided in the cycle after the response handshake.
//  alu_a/b/sel keep their last values outside ISSUE; they are not cleared.
//  Requester IDs >= NREQ are never produced. With only one requester valid, that requester
//   is granted regardless of ptr. Fairness: a continuously valid requester waits at most
//   NREQ-1 grants.
//  req_valid deasserting while not granted is legal; no grant state is kept across cycles.
// TESTING
//  1 Single op: req0 a=8'hF0 b=8'h20 sel=000 -> rsp at T+2, id=0, res=8'h10, c=1.
//  2 Round robin: all 4 valid continuously -> grant order 0,1,2,3,0; each consumed at once.
//  3 Carry mask: req2 sel=100, a=8'hFF, b=8'h0F, ALU model drives c=1 -> res=8'h0F, c=0.
//  4 Backpressure: rsp_ready=0 for 5 cycles -> rsp held stable, req_ready all 0, op_count unchanged.
//  5 Reset in ISSUE: assert rst -> next cycle rsp_valid=0, ptr=0, op_count=0, req_ready follows req_valid[0] only.
//  6 Subtract/counter wrap: sel=001 a=8'h05 b=8'h07 -> res=8'hFE, c=1; preload op_count to all-ones -> 0.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// Round-robin front end for one shared combinational 8-bit ALU: grants one requester,
// registers its operands into the ALU, captures result/carry and hands it back.
module alu_rr_scheduler #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ),
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*8-1:0] req_a,
   input  logic [NREQ*8-1:0] req_b,
   input  logic [NREQ*3-1:0] req_sel,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic [2:0]        alu_sel,
   input  logic [7:0]        alu_res,
   input  logic              alu_c,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [7:0]        rsp_res,
   output logic              rsp_c,
   output logic              busy,
   output logic [CNTW-1:0]   op_count
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic [7:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [2:0]      alu_sel_q, alu_sel_d;
   logic [7:0]      rsp_res_q, rsp_res_d;
   logic            rsp_c_q, rsp_c_d;
   logic [CNTW-1:0] op_count_q, op_count_d;

   logic            gnt_found;
   logic [IDW-1:0]  gnt_idx;
   logic            req_hs, rsp_hs;

   // Rotating priority search starting at ptr; nothing is remembered between cycles.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (int'(ptr_q) + k) % NREQ;
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'(idx);
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req_hs) state_d = S_ISSUE;
         S_ISSUE: state_d = S_RESP;
         S_RESP:  if (rsp_hs) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && gnt_found && !rst) req_ready[gnt_idx] = 1'b1;
      rsp_valid = (state_q == S_RESP);
      busy      = (state_q == S_ISSUE) || (state_q == S_RESP);
   end

   assign req_hs = |(req_valid & req_ready);
   assign rsp_hs = rsp_valid & rsp_ready;

   always_comb begin
      ptr_d      = ptr_q;
      id_d       = id_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_sel_d  = alu_sel_q;
      rsp_id_d   = rsp_id_q;
      rsp_res_d  = rsp_res_q;
      rsp_c_d    = rsp_c_q;
      op_count_d = op_count_q;
      if (req_hs) begin
         alu_a_d   = req_a[8*gnt_idx +: 8];
         alu_b_d   = req_b[8*gnt_idx +: 8];
         alu_sel_d = req_sel[3*gnt_idx +: 3];
         id_d      = gnt_idx;
         ptr_d     = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
      end
      // Logic ops leave the ALU carry undefined, so it is masked off.
      if (state_q == S_ISSUE) begin
         rsp_res_d = alu_res;
         rsp_c_d   = alu_sel_q[2] ? 1'b0 : alu_c;
         rsp_id_d  = id_q;
      end
      if (rsp_hs) op_count_d = op_count_q + CNTW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         id_q       <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_sel_q  <= '0;
         rsp_id_q   <= '0;
         rsp_res_q  <= '0;
         rsp_c_q    <= 1'b0;
         op_count_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_sel_q  <= alu_sel_d;
         rsp_id_q   <= rsp_id_d;
         rsp_res_q  <= rsp_res_d;
         rsp_c_q    <= rsp_c_d;
         op_count_q <= op_count_d;
      end
   end

   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_sel  = alu_sel_q;
   assign rsp_id   = rsp_id_q;
   assign rsp_res  = rsp_res_q;
   assign rsp_c    = rsp_c_q;
   assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a behavioural ALU; small counter width
// so the op_count wrap is reachable quickly.
module tb_alu_rr_scheduler;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int CNTW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid, req_ready;
   logic [NREQ*8-1:0] req_a, req_b;
   logic [NREQ*3-1:0] req_sel;
   logic [7:0]        alu_a, alu_b, alu_res;
   logic [2:0]        alu_sel;
   logic              alu_c;
   logic              rsp_valid, rsp_ready, rsp_c, busy;
   logic [IDW-1:0]    rsp_id;
   logic [7:0]        rsp_res;
   logic [CNTW-1:0]   op_count;

   int total = 0;
   int bad   = 0;
   logic [CNTW-1:0] exp_cnt;

   always #5 clk = ~clk;

   alu_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_res(alu_res), .alu_c(alu_c),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_c(rsp_c),
      .busy(busy), .op_count(op_count)
   );

   // ALU model; carry is deliberately 1 for logic ops to expose missing masking.
   always_comb begin
      alu_c   = 1'b1;
      alu_res = '0;
      case (alu_sel)
         3'd0: {alu_c, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
         3'd1: begin alu_res = alu_a - alu_b; alu_c = (alu_a < alu_b); end
         3'd2: begin alu_res = alu_a << 1;    alu_c = alu_a[7]; end
         3'd3: begin alu_res = alu_a >> 1;    alu_c = alu_a[0]; end
         3'd4: alu_res = alu_a & alu_b;
         3'd5: alu_res = alu_a | alu_b;
         3'd6: alu_res = alu_a ^ alu_b;
         default: alu_res = ~alu_a;
      endcase
   end

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
      req_a[8*i +: 8]   = a;
      req_b[8*i +: 8]   = b;
      req_sel[3*i +: 3] = s;
      req_valid[i]      = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
      req_a = '0; req_b = '0; req_sel = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      req_valid = 4'hF;
      #1;
      total++;
      if ({rsp_valid, busy, req_ready, alu_a, alu_b, alu_sel, rsp_id, rsp_res, rsp_c, op_count} !== '0) begin
         bad++;
         $display("FAIL reset_state: got v=%b busy=%b rdy=%b a=%h b=%h sel=%h id=%0d res=%h c=%b cnt=%0d, want all 0",
                  rsp_valid, busy, req_ready, alu_a, alu_b, alu_sel, rsp_id, rsp_res, rsp_c, op_count);
      end
      req_valid = '0;
      rst = 1'b0;
      exp_cnt = '0;
   endtask

   task automatic test_single_op();
      @(negedge clk);
      set_req(0, 8'hF0, 8'h20, 3'b000);
      rsp_ready = 1'b1;
      #1;
      total++;
      if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready: got %b want 0001", req_ready); end
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      total++;
      if ({busy, rsp_valid, alu_a, alu_b, alu_sel} !== {1'b1, 1'b0, 8'hF0, 8'h20, 3'b000}) begin
         bad++;
         $display("FAIL single_issue: got busy=%b v=%b a=%h b=%h sel=%h want 1 0 f0 20 0", busy, rsp_valid, alu_a, alu_b, alu_sel);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_id, rsp_res, rsp_c} !== {1'b1, 2'd0, 8'h10, 1'b1}) begin
         bad++;
         $display("FAIL single_rsp: got v=%b id=%0d res=%h c=%b want 1 0 10 1", rsp_valid, rsp_id, rsp_res, rsp_c);
      end
      @(posedge clk);
      @(negedge clk);
      exp_cnt++;
      total++;
      if ({rsp_valid, busy, op_count} !== {1'b0, 1'b0, exp_cnt}) begin
         bad++;
         $display("FAIL single_done: got v=%b busy=%b cnt=%0d want 0 0 %0d", rsp_valid, busy, op_count, exp_cnt);
      end
   endtask

   task automatic test_round_robin();
      logic [IDW-1:0] exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [7:0]     exp_res [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h10 * (i + 1)), 8'(i + 1), 3'b000);
      rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         total++;
         if (req_ready !== (4'b0001 << exp_id[k])) begin
            bad++; $display("FAIL rr_grant%0d: got %b want id %0d", k, req_ready, exp_id[k]);
         end
         @(posedge clk); @(negedge clk);
         @(posedge clk); @(negedge clk);
         total++;
         if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, exp_id[k], exp_res[k]}) begin
            bad++;
            $display("FAIL rr_rsp%0d: got v=%b id=%0d res=%h want 1 %0d %h", k, rsp_valid, rsp_id, rsp_res, exp_id[k], exp_res[k]);
         end
         @(posedge clk); @(negedge clk);
         exp_cnt++;
      end
      req_valid = '0;
      total++;
      if (op_count !== exp_cnt) begin bad++; $display("FAIL rr_count: got %0d want %0d", op_count, exp_cnt); end
   endtask

   task automatic test_carry_mask();
      // ptr sits at 1 here; a lone requester must still win.
      set_req(2, 8'hFF, 8'h0F, 3'b100);
      #1;
      total++;
      if (req_ready !== 4'b0100) begin bad++; $display("FAIL mask_ready: got %b want 0100", req_ready); end
      @(posedge clk); @(negedge clk);
      req_valid = '0;
      @(posedge clk); @(negedge clk);
      total++;
      if ({rsp_valid, rsp_id, rsp_res, rsp_c} !== {1'b1, 2'd2, 8'h0F, 1'b0}) begin
         bad++;
         $display("FAIL mask_rsp: got v=%b id=%0d res=%h c=%b want 1 2 0f 0", rsp_valid, rsp_id, rsp_res, rsp_c);
      end
      @(posedge clk); @(negedge clk);
      exp_cnt++;
   endtask

   task automatic test_backpressure();
      set_req(1, 8'h81, 8'h00, 3'b010);
      rsp_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      req_valid = 4'hF;
      @(posedge clk); @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         #1;
         total++;
         if ({rsp_valid, rsp_id, rsp_res, rsp_c, req_ready, op_count} !== {1'b1, 2'd1, 8'h02, 1'b1, 4'b0000, exp_cnt}) begin
            bad++;
            $display("FAIL bp_hold%0d: got v=%b id=%0d res=%h c=%b rdy=%b cnt=%0d want 1 1 02 1 0000 %0d",
                     k, rsp_valid, rsp_id, rsp_res, rsp_c, req_ready, op_count, exp_cnt);
         end
         @(posedge clk); @(negedge clk);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      exp_cnt++;
      total++;
      if ({rsp_valid, op_count} !== {1'b0, exp_cnt}) begin
         bad++; $display("FAIL bp_release: got v=%b cnt=%0d want 0 %0d", rsp_valid, op_count, exp_cnt);
      end
   endtask

   task automatic test_reset_in_issue();
      set_req(3, 8'h12, 8'h34, 3'b110);
      @(posedge clk); @(negedge clk);
      req_valid = '0;
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      exp_cnt = '0;
      req_valid = 4'hF;
      #1;
      total++;
      if ({rsp_valid, busy, op_count, req_ready} !== {1'b0, 1'b0, exp_cnt, 4'b0001}) begin
         bad++;
         $display("FAIL rst_issue: got v=%b busy=%b cnt=%0d rdy=%b want 0 0 0 0001", rsp_valid, busy, op_count, req_ready);
      end
      req_valid = '0;
      @(posedge clk); @(negedge clk);
      total++;
      if ({rsp_valid, busy} !== 2'b00) begin
         bad++; $display("FAIL rst_no_rsp: got v=%b busy=%b want 0 0", rsp_valid, busy);
      end
   endtask

   task automatic test_sub_wrap();
      rsp_ready = 1'b1;
      set_req(0, 8'h05, 8'h07, 3'b001);
      @(posedge clk); @(negedge clk);
      req_valid = '0;
      @(posedge clk); @(negedge clk);
      total++;
      if ({rsp_valid, rsp_id, rsp_res, rsp_c} !== {1'b1, 2'd0, 8'hFE, 1'b1}) begin
         bad++;
         $display("FAIL sub_rsp: got v=%b id=%0d res=%h c=%b want 1 0 fe 1", rsp_valid, rsp_id, rsp_res, rsp_c);
      end
      @(posedge clk); @(negedge clk);
      exp_cnt++;
      // Run the counter up to all-ones, then one more op must wrap it to zero.
      for (int n = 0; n < (1 << CNTW) - 1; n++) begin
         set_req(1, 8'h01, 8'h01, 3'b000);
         @(posedge clk); @(negedge clk);
         req_valid = '0;
         repeat (2) begin @(posedge clk); @(negedge clk); end
         exp_cnt++;
         if (n == (1 << CNTW) - 3) begin
            total++;
            if (op_count !== '1) begin bad++; $display("FAIL cnt_full: got %0d want %0d", op_count, (1 << CNTW) - 1); end
         end
      end
      total++;
      if (op_count !== '0 || exp_cnt !== '0) begin
         bad++; $display("FAIL cnt_wrap: got %0d want 0", op_count);
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
      req_a = '0; req_b = '0; req_sel = '0;
      exp_cnt = '0;
      test_reset();
      test_single_op();
      test_round_robin();
      test_carry_mask();
      test_backpressure();
      test_reset_in_issue();
      test_sub_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
